// File: rtl/imem_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
package imem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    FETCH  = 1'b0,
    LOADER = 1'b1
  } req_e;

  // Which port, if any, is owed read data in the next cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_F = 2'd1,
    RESP_L = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a loader lock that masks the fetch port.
module rr_arb2
  import imem_pkg::*;
(
  input  logic en,
  input  logic req_f,
  input  logic req_l,
  input  logic lock,
  input  req_e last_grant,
  output logic gnt_f,
  output logic gnt_l,
  output logic upd
);

  always_comb begin
    gnt_f = 1'b0;
    gnt_l = 1'b0;
    if (en) begin
      if (lock) begin
        gnt_l = req_l;
      end else if (req_f && req_l) begin
        // The port that did not win last time takes this conflict.
        if (last_grant == LOADER) gnt_f = 1'b1;
        else                      gnt_l = 1'b1;
      end else begin
        gnt_f = req_f;
        gnt_l = req_l;
      end
    end
  end

  // Locked grants leave the round-robin history untouched.
  assign upd = en && !lock && (gnt_f || gnt_l);

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port instruction memory between the CPU fetch port and
// a loader port; reads return one cycle after grant.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_ren,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  state_e            state_q, state_d;
  req_e              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] f_hold_q, f_hold_d;
  logic [DATA_W-1:0] l_hold_q, l_hold_d;
  logic              arb_upd;
  logic              resp_f, resp_l;

  rr_arb2 u_arb (
    .en         (reset_n),
    .req_f      (f_req),
    .req_l      (l_req),
    .lock       (l_lock),
    .last_grant (last_grant_q),
    .gnt_f      (f_gnt),
    .gnt_l      (l_gnt),
    .upd        (arb_upd)
  );

  always_comb begin
    m_ren   = 1'b0;
    m_wen   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (f_gnt) begin
      m_ren  = 1'b1;
      m_addr = f_addr;
    end else if (l_gnt) begin
      m_ren   = !l_we;
      m_wen   = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end
  end

  // A response owed across a reset assertion is dropped, not delivered.
  assign resp_f   = reset_n && (state_q == RESP_F);
  assign resp_l   = reset_n && (state_q == RESP_L);
  assign f_rvalid = resp_f;
  assign l_rvalid = resp_l;
  assign f_rdata  = resp_f ? m_rdata : f_hold_q;
  assign l_rdata  = resp_l ? m_rdata : l_hold_q;

  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    f_hold_d     = f_rdata;
    l_hold_d     = l_rdata;
    if (f_gnt)               state_d = RESP_F;
    else if (l_gnt && !l_we) state_d = RESP_L;
    if (arb_upd) last_grant_d = f_gnt ? FETCH : LOADER;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= LOADER;
      f_hold_q     <= '0;
      l_hold_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      f_hold_q     <= f_hold_d;
      l_hold_q     <= l_hold_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a one-cycle-latency memory model.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        f_req, f_gnt, f_rvalid;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        m_ren, m_wen;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  // Untouched word i reads as 0x1000_0000 + i.
  logic [63:0] written = '0;
  logic [31:0] wmem [64];

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always @(posedge clk) begin
    if (m_wen) begin
      wmem[m_addr[7:2]]    <= m_wdata;
      written[m_addr[7:2]] <= 1'b1;
    end
    if (m_ren)
      m_rdata <= written[m_addr[7:2]] ? wmem[m_addr[7:2]] : 32'h1000_0000 + {26'd0, m_addr[7:2]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_lock = 0;
  endtask

  initial begin
    idle_in();
    reset_n = 0;
    // Reset: grants and memory strobes forced low despite requests.
    f_req = 1; l_req = 1;
    smp(); chk("rst_fgnt", f_gnt, 0); chk("rst_lgnt", l_gnt, 0); chk("rst_mren", m_ren, 0);
    cyc(); smp();
    chk("rst_frv", f_rvalid, 0); chk("rst_lrv", l_rvalid, 0);
    chk("rst_frd", f_rdata, 0); chk("rst_lrd", l_rdata, 0);
    cyc(); idle_in(); reset_n = 1;

    // Fetch-only stream 0x0, 0x4, 0x8.
    f_req = 1; f_addr = 32'h0;
    smp(); chk("s1_gnt0", f_gnt, 1); chk("s1_mren", m_ren, 1); chk("s1_rv0", f_rvalid, 0);
    cyc(); f_addr = 32'h4;
    smp(); chk("s1_gnt1", f_gnt, 1); chk("s1_maddr", m_addr, 32'h4);
    chk("s1_rv1", f_rvalid, 1); chk("s1_rd0", f_rdata, 32'h1000_0000);
    cyc(); f_addr = 32'h8;
    smp(); chk("s1_gnt2", f_gnt, 1); chk("s1_rd1", f_rdata, 32'h1000_0001);
    cyc(); idle_in();
    smp(); chk("s1_nognt", f_gnt, 0); chk("s1_idle_mren", m_ren, 0); chk("s1_idle_maddr", m_addr, 0);
    chk("s1_rv2", f_rvalid, 1); chk("s1_rd2", f_rdata, 32'h1000_0002);
    cyc();
    smp(); chk("s1_rvoff", f_rvalid, 0); chk("s1_hold", f_rdata, 32'h1000_0002);

    // Fresh reset, then continuous conflict: fetch first, then alternate.
    cyc(); reset_n = 0; cyc(); reset_n = 1;
    f_req = 1; f_addr = 32'h0; l_req = 1; l_addr = 32'h10;
    smp(); chk("c0_f", f_gnt, 1); chk("c0_l", l_gnt, 0);
    cyc();
    smp(); chk("c1_l", l_gnt, 1); chk("c1_f", f_gnt, 0);
    chk("c1_frv", f_rvalid, 1); chk("c1_frd", f_rdata, 32'h1000_0000); chk("c1_lrv", l_rvalid, 0);
    cyc();
    smp(); chk("c2_f", f_gnt, 1); chk("c2_lrv", l_rvalid, 1); chk("c2_lrd", l_rdata, 32'h1000_0004);
    chk("c2_frv", f_rvalid, 0);
    cyc();
    smp(); chk("c3_l", l_gnt, 1); chk("c3_frv", f_rvalid, 1);
    cyc();
    smp(); chk("c4_f", f_gnt, 1); chk("c4_lrv", l_rvalid, 1);
    cyc(); idle_in();
    smp(); chk("c5_frv", f_rvalid, 1); chk("c5_lrv", l_rvalid, 0);
    cyc();

    // Locked loader write/read; fetch is starved and history is frozen.
    l_lock = 1; l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'hDEAD_BEEF; f_req = 1;
    smp(); chk("lk_lgnt", l_gnt, 1); chk("lk_fgnt", f_gnt, 0); chk("lk_mwen", m_wen, 1);
    chk("lk_mren", m_ren, 0); chk("lk_wdata", m_wdata, 32'hDEAD_BEEF);
    cyc(); l_we = 0; l_wdata = 0;
    smp(); chk("lk2_fgnt", f_gnt, 0); chk("lk2_lgnt", l_gnt, 1); chk("lk2_lrv", l_rvalid, 0);
    cyc(); l_lock = 0; l_addr = 32'h10;
    smp(); chk("lk3_lgnt", l_gnt, 1); chk("lk3_fgnt", f_gnt, 0);
    chk("lk3_lrv", l_rvalid, 1); chk("lk3_lrd", l_rdata, 32'hDEAD_BEEF);
    cyc(); l_req = 0;
    smp(); chk("lk4_fgnt", f_gnt, 1); chk("lk4_lrd", l_rdata, 32'h1000_0004);
    cyc(); idle_in();
    smp(); chk("lk5_frv", f_rvalid, 1); chk("lk5_frd", f_rdata, 32'h1000_0000);
    cyc();

    // Loader write then fetch of the same word.
    l_req = 1; l_we = 1; l_addr = 32'h24; l_wdata = 32'hCAFE_F00D;
    smp(); chk("wf_lgnt", l_gnt, 1); chk("wf_mwen", m_wen, 1);
    cyc(); idle_in(); f_req = 1; f_addr = 32'h24;
    smp(); chk("wf_fgnt", f_gnt, 1); chk("wf_lrv0", l_rvalid, 0);
    cyc(); idle_in();
    smp(); chk("wf_frv", f_rvalid, 1); chk("wf_frd", f_rdata, 32'hCAFE_F00D); chk("wf_lrv1", l_rvalid, 0);
    cyc();

    // Reset right after a fetch grant drops its response.
    f_req = 1; f_addr = 32'h8;
    smp(); chk("rr_fgnt", f_gnt, 1);
    cyc(); idle_in(); reset_n = 0;
    smp(); chk("rr_frv", f_rvalid, 0); chk("rr_mren", m_ren, 0);
    cyc(); reset_n = 1;
    smp(); chk("rr_frv2", f_rvalid, 0); chk("rr_frd", f_rdata, 0); chk("rr_lrd", l_rdata, 0);
    chk("rr_mwen", m_wen, 0); chk("rr_maddr", m_addr, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32: instruction/data word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 f_req  input  1  fetch port (CPU) read request.
REQ-006 f_addr  input  ADDR_W  fetch byte address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  fetch read data valid.
REQ-009 f_rdata  output  DATA_W  fetch read data.
REQ-010 l_req  input  1  loader port (bootloader/UART loader) request.
REQ-011 l_we  input  1  loader write (1) / read (0).
REQ-012 l_addr  input  ADDR_W  loader byte address.
REQ-013 l_wdata  input  DATA_W  loader write data.
REQ-014 l_lock  input  1  loader exclusive mode; while high, fetch is never granted.
REQ-015 l_gnt  output  1  loader request accepted this cycle.
REQ-016 l_rvalid  output  1  loader read data valid.
REQ-017 l_rdata  output  DATA_W  loader read data.
REQ-018 m_ren  output  1  memory read enable.
REQ-019 m_wen  output  1  memory write enable.
REQ-020 m_addr  output  ADDR_W  memory byte address; memory uses bits [ADDR_W-1:2] as word index.
REQ-021 m_wdata  output  DATA_W  memory write data.
REQ-022 m_rdata  input  DATA_W  memory read data, valid exactly one cycle after m_ren.

Function
REQ-023 Grant is combinational from current requests and state; at most one of f_gnt, l_gnt high per cycle.
REQ-024 Granted request drives m_addr/m_ren/m_wen/m_wdata in the same cycle; no grant -> m_ren=m_wen=0, m_addr/m_wdata=0.
REQ-025 Requester holds req/addr/wdata stable until gnt; request is consumed on the gnt cycle.
REQ-026 Arbitration: single requester wins; on conflict, round-robin via 1-bit last_grant register (requester not granted last wins); last_grant resets to LOADER, so fetch wins first conflict.
REQ-027 l_lock=1: f_gnt=0 regardless of f_req; loader granted whenever l_req=1; last_grant not updated by locked grants.
REQ-028 Read latency fixed at 1 cycle: read granted in cycle N -> matching rvalid high in cycle N+1 only, rdata = m_rdata in N+1.
REQ-029 Response routing via registered resp_owner/resp_pending; back-to-back reads from either port (one per cycle) sustain full throughput.
REQ-030 Loader write (l_we=1) produces m_wen=1, no rvalid; write followed next cycle by read of same address returns new data.
REQ-031 rdata of a non-valid port is held at its last value; only rvalid is qualifying.
REQ-032 States: IDLE (no response pending), RESP_F, RESP_L (response owed to that port next cycle); any state -> granted read's owner state, else IDLE.
REQ-033 Simultaneous new grant and pending response permitted; the two ports' rvalid never both high.

Reset
REQ-034 While reset_n=0 at clock edge: state=IDLE, last_grant=LOADER, f_rvalid=l_rvalid=0, f_rdata=l_rdata=0.
REQ-035 Reset mid-transaction discards the pending response; no rvalid in the cycle after reset release.
REQ-036 During reset, gnt and m_ren/m_wen are forced 0.

Structure
REQ-037 Shared package imem_pkg holds requester enum (FETCH, LOADER), state enum, and default ADDR_W/DATA_W constants.
REQ-038 One sub-module, rr_arb2 (2-way round-robin with lock mask); response routing and state kept in imem_arbiter.

Verification
REQ-039 f_req only, f_addr=0x0,0x4,0x8 consecutive -> f_gnt each cycle, f_rvalid next cycles with MEM[0],MEM[1],MEM[2].
REQ-040 f_req and l_req (read 0x10) both high from reset -> cycle 0 f_gnt, cycle 1 l_gnt, alternating thereafter.
REQ-041 l_lock=1, l_we=1 writes 0xDEADBEEF at 0x20, f_req high -> f_gnt stays 0; following l read 0x20 returns 0xDEADBEEF.
REQ-042 f read granted, reset_n=0 next cycle -> no f_rvalid; post-reset outputs all 0.
REQ-043 Loader write then fetch read same address next cycle -> f_rdata equals written value, l_rvalid never asserted.
